rotating_register_file: RTL and testbench
=========================================

# rotating_register_file

Parametrised multi-port register file for CGRA processing elements. It generalises the fixed 4-write/8-read, 8x32 register file to configurable port counts, depth and width. It adds a modulo-scheduling rotating region addressed through a base pointer, deterministic write-collision priority, and a synchronous clear. It sits between the PE crossbar inputs and the FU operand muxes; all reads are registered.

## Interface
Parameters:
- NUM_IN, 4, number of write ports (1..8)
- NUM_OUT, 8, number of read ports (1..16)
- LOG2REGS, 3, log2 of register count; REGS = 2**LOG2REGS
- SIZE, 32, data width in bits
- ROT_REGS, 4, size of the rotating region, physical registers 0..ROT_REGS-1 (0..REGS; 0 disables rotation)

Ports:
- CGRA_Clock  in  1  clock, all state updates on rising edge
- CGRA_Reset  in  1  reset, asynchronous and active-high
- clear  in  1  synchronous clear of array and base pointer
- rotate  in  1  advance rotating base pointer by one (iteration boundary)
- WE  in  NUM_IN  per-port write enable, bit i for port i
- address_in  in  NUM_IN*LOG2REGS  packed logical write addresses, port i at [i*LOG2REGS +: LOG2REGS]
- in  in  NUM_IN*SIZE  packed write data, port i at [i*SIZE +: SIZE]
- address_out  in  NUM_OUT*LOG2REGS  packed logical read addresses
- out  out  NUM_OUT*SIZE  packed registered read data
- rot_base  out  max(1,clog2(ROT_REGS))  current base pointer

## Operation
- Address translation applies to every port. For logical address a < ROT_REGS, the physical address is (a + base) mod ROT_REGS, computed as sum minus ROT_REGS when sum >= ROT_REGS, with no divider. For a >= ROT_REGS, physical = a (static region).
- Translation uses the pre-edge base, including in the cycle where rotate is asserted.
- Read: at each edge, out[j] <= array[phys(address_out[j])], using pre-edge array contents (read-before-write), unless bypass is enabled (see Configuration).
- Write: for each i with WE[i]=1, array[phys(address_in[i])] <= in[i].
- Collision: when several ports target the same physical address, the highest-indexed port wins. Other addresses are unaffected.
- Rotate: base <= (base + 1) mod ROT_REGS, wrapping from ROT_REGS-1 to 0. When ROT_REGS is 0 or 1, base stays 0 and rotate is ignored.
- Clear: all array entries <= 0 and base <= 0. Clear overrides writes and rotate in the same cycle. Reads in that cycle still return the pre-edge contents.
- Out-of-range logical addresses cannot occur, since the full LOG2REGS range maps to REGS registers.

## Timing
- Reset (async assert) sets all array entries, every out lane and rot_base to 0 immediately. Deassertion is synchronised externally. The first active edge after deassertion performs normal operation.
- Reset asserted mid-operation discards pending writes and rotate of that cycle.
- Read latency is 1 cycle: address presented before edge k produces data on out after edge k.
- Write-to-read (no bypass): a write at edge k is returned by a read sampled at edge k+1.
- Rotate at edge k: rot_base changes after edge k, and the new mapping applies from edge k+1.
- Writes and reads in the rotating cycle use the old mapping.
- No handshakes. Every port is accepted every cycle, so throughput is NUM_IN writes and NUM_OUT reads per cycle.

## Configuration
- RF_BYPASS_EN defined: a read whose physical address matches a same-cycle write returns that write's data on out after the same edge. The winning write under the collision priority is forwarded. Clear in the same cycle suppresses forwarding, and pre-edge data is returned.
- RF_BYPASS_EN undefined: strict read-before-write as above. No forwarding logic is synthesised.

## Test plan
- Reset: drive data, pulse CGRA_Reset between edges -> all out lanes and rot_base read 0 without a clock edge; reading all 8 addresses afterwards returns 0.
- Write/read, ROT_REGS=0: write 0xDEADBEEF to addr 5 via port 2 at edge k, read addr 5 on lane 7 -> out lane 7 is old value 0 after edge k and 0xDEADBEEF after edge k+1 (bypass off); 0xDEADBEEF after edge k (bypass on).
- Collision: ports 0, 1, 3 write 0x11, 0x22, 0x33 to addr 2 in one cycle -> addr 2 reads 0x33.
- Rotation, ROT_REGS=4: write 0xA to logical 1 (base 0), then rotate 3 times -> rot_base goes 1, 2, 3. Logical 2 returns 0xA when base=3 (phys (2+3) mod 4 = 1). A fourth rotate wraps rot_base to 0.
- Static region: with ROT_REGS=4, write 0x55 to addr 6, rotate twice -> addr 6 still reads 0x55.
- Clear with simultaneous write and rotate: array filled, base=2 -> after the edge all reads 0 and rot_base 0. The same-edge read returns pre-clear data.

Source files
------------

// File: rtl/rotating_register_file.sv
// Multi-port CGRA register file with a modulo-scheduled rotating region, registered reads and synchronous clear.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module rotating_register_file #(
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned NUM_OUT  = 8,
  parameter int unsigned LOG2REGS = 3,
  parameter int unsigned SIZE     = 32,
  parameter int unsigned ROT_REGS = 4
) (
  input  logic                                            CGRA_Clock,
  input  logic                                            CGRA_Reset,
  input  logic                                            clear,
  input  logic                                            rotate,
  input  logic [NUM_IN-1:0]                               WE,
  input  logic [NUM_IN*LOG2REGS-1:0]                      address_in,
  input  logic [NUM_IN*SIZE-1:0]                          in,
  input  logic [NUM_OUT*LOG2REGS-1:0]                     address_out,
  output logic [NUM_OUT*SIZE-1:0]                         out,
  output logic [((ROT_REGS > 1) ? $clog2(ROT_REGS) : 1)-1:0] rot_base
);

  localparam int unsigned REGS = 2 ** LOG2REGS;
  localparam int unsigned BW   = (ROT_REGS > 1) ? $clog2(ROT_REGS) : 1;
  localparam logic [LOG2REGS:0] ROT_L     = (LOG2REGS + 1)'(ROT_REGS);
  localparam logic [BW-1:0]     BASE_LAST = BW'(ROT_REGS - 1);

  logic [SIZE-1:0]     mem     [REGS];
  logic [SIZE-1:0]     mem_nxt [REGS];
  logic [LOG2REGS-1:0] waddr   [NUM_IN];
  logic [LOG2REGS-1:0] raddr   [NUM_OUT];
  logic [NUM_OUT*SIZE-1:0] out_nxt;
  logic [BW-1:0]           base_nxt;

  // Logical-to-physical mapping: rotating region wraps with a compare-subtract, static region passes through.
  function automatic logic [LOG2REGS-1:0] phys(input logic [LOG2REGS-1:0] a, input logic [BW-1:0] b);
    logic [LOG2REGS:0] s;
    s = {1'b0, a};
    if (ROT_REGS != 0 && s < ROT_L) begin
      s = s + (LOG2REGS + 1)'(b);
      if (s >= ROT_L) s = s - ROT_L;
    end
    return LOG2REGS'(s);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++)
      waddr[i] = phys(address_in[i*LOG2REGS +: LOG2REGS], rot_base);
    for (int unsigned j = 0; j < NUM_OUT; j++)
      raddr[j] = phys(address_out[j*LOG2REGS +: LOG2REGS], rot_base);
  end

  // Later ports overwrite earlier ones, so the highest-indexed writer wins a collision.
  always_comb begin
    mem_nxt = mem;
    for (int unsigned i = 0; i < NUM_IN; i++)
      if (WE[i]) mem_nxt[waddr[i]] = in[i*SIZE +: SIZE];
    if (clear) mem_nxt = '{default: '0};
  end

  always_comb begin
    base_nxt = rot_base;
    if (clear) base_nxt = '0;
    else if (rotate && ROT_REGS > 1)
      base_nxt = (rot_base == BASE_LAST) ? '0 : rot_base + BW'(1);
  end

  always_comb begin
    out_nxt = '0;
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
`ifdef RF_BYPASS_EN
      // Clear suppresses forwarding; otherwise the post-write view already holds the winning write.
      out_nxt[j*SIZE +: SIZE] = clear ? mem[raddr[j]] : mem_nxt[raddr[j]];
`else
      out_nxt[j*SIZE +: SIZE] = mem[raddr[j]];
`endif
    end
  end

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      mem      <= '{default: '0};
      out      <= '0;
      rot_base <= '0;
    end else begin
      mem      <= mem_nxt;
      out      <= out_nxt;
      rot_base <= base_nxt;
    end
  end

endmodule

// File: tb/tb_rotating_register_file.sv
// Directed self-checking bench for rotating_register_file at default parameters (4W/8R, 8x32, 4 rotating).
module tb_rotating_register_file;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         rotate;
  logic [3:0]   we;
  logic [11:0]  ain;
  logic [127:0] din;
  logic [23:0]  aout;
  logic [255:0] dout;
  logic [1:0]   rbase;

  int checks = 0;
  int passed = 0;

  rotating_register_file dut (
    .CGRA_Clock (clk),
    .CGRA_Reset (rst),
    .clear      (clear),
    .rotate     (rotate),
    .WE         (we),
    .address_in (ain),
    .in         (din),
    .address_out(aout),
    .out        (dout),
    .rot_base   (rbase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lane(input int j);
    return dout[j*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0;
    clear = 1'b0;
    rotate = 1'b0;
  endtask

  task automatic wr(input logic [1:0] p, input logic [2:0] a, input logic [31:0] d);
    we[p] = 1'b1;
    ain[p*3 +: 3] = a;
    din[p*32 +: 32] = d;
  endtask

  task automatic rd(input logic [2:0] j, input logic [2:0] a);
    aout[j*3 +: 3] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    ain = '0; din = '0; aout = '0;
    tick(); tick();
    rst = 1'b0;
    wr(2'd0, 3'd5, 32'h1234);
    rotate = 1'b1;
    tick();
    idle();
    for (int j = 0; j < 8; j++) rd(3'(j), 3'd5);
    tick();
    checks++;
    if (lane(0) !== 32'h1234) $display("FAIL rst_pre lane0 got %h exp %h", lane(0), 32'h1234);
    else passed++;
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (lane(j) !== 32'h0) $display("FAIL rst_async lane%0d got %h exp 0", j, lane(j));
      else passed++;
    end
    checks++;
    if (rbase !== 2'd0) $display("FAIL rst_async rot_base got %0d exp 0", rbase);
    else passed++;
    #1 rst = 1'b0;
    for (int j = 0; j < 8; j++) rd(3'(j), 3'(j));
    tick();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (lane(j) !== 32'h0) $display("FAIL rst_array addr%0d got %h exp 0", j, lane(j));
      else passed++;
    end
  endtask

  task automatic test_write_read();
    logic [31:0] exp_k;
`ifdef RF_BYPASS_EN
    exp_k = 32'hDEADBEEF;
`else
    exp_k = 32'h0;
`endif
    wr(2'd2, 3'd5, 32'hDEADBEEF);
    rd(3'd7, 3'd5);
    tick();
    checks++;
    if (lane(7) !== exp_k) $display("FAIL wr_rd_edge_k lane7 got %h exp %h", lane(7), exp_k);
    else passed++;
    idle();
    tick();
    checks++;
    if (lane(7) !== 32'hDEADBEEF) $display("FAIL wr_rd_edge_k1 lane7 got %h exp %h", lane(7), 32'hDEADBEEF);
    else passed++;
  endtask

  task automatic test_collision();
    wr(2'd0, 3'd2, 32'h11);
    wr(2'd1, 3'd2, 32'h22);
    wr(2'd3, 3'd2, 32'h33);
    wr(2'd2, 3'd7, 32'h44);
    tick();
    idle();
    rd(3'd0, 3'd2);
    rd(3'd1, 3'd7);
    tick();
    checks++;
    if (lane(0) !== 32'h33) $display("FAIL collision addr2 got %h exp %h", lane(0), 32'h33);
    else passed++;
    checks++;
    if (lane(1) !== 32'h44) $display("FAIL collision addr7 got %h exp %h", lane(1), 32'h44);
    else passed++;
  endtask

  task automatic test_rotation();
    wr(2'd0, 3'd1, 32'hA);
    tick();
    idle();
    rotate = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (rbase !== 2'(k)) $display("FAIL rotate_step rot_base got %0d exp %0d", rbase, k);
      else passed++;
    end
    rotate = 1'b0;
    rd(3'd0, 3'd2);
    rd(3'd1, 3'd3);
    tick();
    checks++;
    if (lane(0) !== 32'hA) $display("FAIL rotate_log2 got %h exp %h", lane(0), 32'hA);
    else passed++;
    checks++;
    if (lane(1) !== 32'h33) $display("FAIL rotate_log3 got %h exp %h", lane(1), 32'h33);
    else passed++;
    rotate = 1'b1;
    tick();
    checks++;
    if (rbase !== 2'd0) $display("FAIL rotate_wrap rot_base got %0d exp 0", rbase);
    else passed++;
    // write in the rotating cycle lands at the old-mapping physical address 0
    wr(2'd0, 3'd0, 32'hB7);
    tick();
    idle();
    checks++;
    if (rbase !== 2'd1) $display("FAIL rotate_wr rot_base got %0d exp 1", rbase);
    else passed++;
    rd(3'd2, 3'd3);
    tick();
    checks++;
    if (lane(2) !== 32'hB7) $display("FAIL rotate_old_map got %h exp %h", lane(2), 32'hB7);
    else passed++;
  endtask

  task automatic test_static();
    wr(2'd0, 3'd6, 32'h55);
    tick();
    idle();
    rotate = 1'b1;
    tick(); tick();
    rotate = 1'b0;
    rd(3'd3, 3'd6);
    tick();
    checks++;
    if (lane(3) !== 32'h55) $display("FAIL static addr6 got %h exp %h", lane(3), 32'h55);
    else passed++;
    checks++;
    if (rbase !== 2'd3) $display("FAIL static rot_base got %0d exp 3", rbase);
    else passed++;
  endtask

  task automatic test_clear();
    rotate = 1'b1;
    tick(); tick(); tick();
    rotate = 1'b0;
    checks++;
    if (rbase !== 2'd2) $display("FAIL clr_setup rot_base got %0d exp 2", rbase);
    else passed++;
    for (int p = 0; p < 4; p++) wr(2'(p), 3'(p), 32'h100 + 32'(p));
    tick();
    for (int p = 0; p < 4; p++) wr(2'(p), 3'(4 + p), 32'h104 + 32'(p));
    tick();
    idle();
    for (int j = 0; j < 8; j++) rd(3'(j), 3'(j));
    clear = 1'b1;
    rotate = 1'b1;
    for (int p = 0; p < 4; p++) wr(2'(p), 3'(p), 32'hFFFF);
    tick();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (lane(j) !== 32'h100 + 32'(j)) $display("FAIL clr_same_edge lane%0d got %h exp %h", j, lane(j), 32'h100 + 32'(j));
      else passed++;
    end
    checks++;
    if (rbase !== 2'd0) $display("FAIL clr rot_base got %0d exp 0", rbase);
    else passed++;
    idle();
    tick();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (lane(j) !== 32'h0) $display("FAIL clr_after lane%0d got %h exp 0", j, lane(j));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_rotation();
    test_static();
    test_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
